pipe_reg_elastic: RTL and testbench

- Parametrised successor to the flush/write pipeline register: a DEPTH-stage chain of WIDTH-bit registers with per-stage valid bits and a valid/ready handshake.
- Sits between CPU pipeline stages (e.g. IF/ID through MEM/WB) where stalls come from downstream back-pressure.
- Collapses bubbles, sustains 1 transfer/cycle, supports a global flush and a global stall (freeze).

---
 rtl/pipe_reg_elastic.sv | 93 +++++++++
 tb/tb_pipe_reg_elastic.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_elastic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_reg_elastic                                                         |
// | DEPTH-stage elastic pipeline register with valid/ready handshake,        |
// | bubble collapse, global flush and global stall.                          |
// | Optional occupancy output occ_o: define PIPE_REG_ELASTIC_OCC_EN.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_reg_elastic #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       stall_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o
`ifdef PIPE_REG_ELASTIC_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ_o
`endif
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] mv;
  logic             accept;

  // A stage moves when it is valid and its successor is empty or moving too.
  always_comb begin
    mv = '0;
    mv[DEPTH-1] = v[DEPTH-1] & out_ready_i;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      mv[k] = v[k] & (~v[k+1] | mv[k+1]);
    end
  end

  assign in_ready_o  = ~flush_i & ~stall_i & (~v[0] | mv[0]);
  assign out_valid_o = v[DEPTH-1] & ~stall_i;
  assign out_data_o  = d[DEPTH-1];
  assign accept      = in_valid_i & in_ready_o;

  // Emptied stages are zeroed so invalid slots always carry d=0.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else if (!stall_i) begin
      if (accept) begin
        v[0] <= 1'b1;
        d[0] <= in_data_i;
      end else if (mv[0]) begin
        v[0] <= 1'b0;
        d[0] <= '0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (mv[k-1]) begin
          v[k] <= 1'b1;
          d[k] <= d[k-1];
        end else if (mv[k]) begin
          v[k] <= 1'b0;
          d[k] <= '0;
        end
      end
    end
  end

`ifdef PIPE_REG_ELASTIC_OCC_EN
  localparam int OW = $clog2(DEPTH + 1);

  logic pop;
  assign pop = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      occ_o <= '0;
    end else if (accept && !pop) begin
      occ_o <= occ_o + OW'(1);
    end else if (!accept && pop) begin
      occ_o <= occ_o - OW'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_elastic.sv
`default_nettype none
// Self-checking bench for pipe_reg_elastic: vector table on a DEPTH=2
// instance plus a hand-written bubble-collapse sequence on a DEPTH=4 instance.
module tb_pipe_reg_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=2 instance
  logic        rst2, flush2, stall2, iv2, ir2, ov2, or2;
  logic [31:0] id2, od2;
  logic [1:0]  occ2;

  // DEPTH=4 instance
  logic        rst4, flush4, stall4, iv4, ir4, ov4, or4;
  logic [31:0] id4, od4;
  logic [2:0]  occ4;

  pipe_reg_elastic #(.WIDTH(32), .DEPTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .flush_i(flush2), .stall_i(stall2),
    .in_valid_i(iv2), .in_ready_o(ir2), .in_data_i(id2),
    .out_valid_o(ov2), .out_ready_i(or2), .out_data_o(od2)
`ifdef PIPE_REG_ELASTIC_OCC_EN
    , .occ_o(occ2)
`endif
  );

  pipe_reg_elastic #(.WIDTH(32), .DEPTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .flush_i(flush4), .stall_i(stall4),
    .in_valid_i(iv4), .in_ready_o(ir4), .in_data_i(id4),
    .out_valid_o(ov4), .out_ready_i(or4), .out_data_o(od4)
`ifdef PIPE_REG_ELASTIC_OCC_EN
    , .occ_o(occ4)
`endif
  );

`ifndef PIPE_REG_ELASTIC_OCC_EN
  assign occ2 = '0;
  assign occ4 = '0;
`endif

  typedef struct {
    bit          chk;
    bit          rst, flush, stall, iv, ordy;
    logic [31:0] din;
    bit          e_ir, e_ov;
    logic [31:0] e_od;
    int          e_occ;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit chk, bit rst, bit flush, bit stall, bit iv,
                              logic [31:0] din, bit ordy, bit e_ir, bit e_ov,
                              logic [31:0] e_od, int e_occ);
    vec_t t;
    t.chk = chk; t.rst = rst; t.flush = flush; t.stall = stall; t.iv = iv;
    t.din = din; t.ordy = ordy; t.e_ir = e_ir; t.e_ov = e_ov; t.e_od = e_od;
    t.e_occ = e_occ;
    vq.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step4(input bit rst, input bit iv, input logic [31:0] din, input bit ordy);
    @(negedge clk);
    rst4 = rst; flush4 = 1'b0; stall4 = 1'b0; iv4 = iv; id4 = din; or4 = ordy;
    #1;
  endtask

  task automatic check4(input string name, input bit e_ir, input bit e_ov,
                        input logic [31:0] e_od, input int e_occ);
    check({name, " in_ready"}, {31'd0, ir4}, {31'd0, e_ir});
    check({name, " out_valid"}, {31'd0, ov4}, {31'd0, e_ov});
    check({name, " out_data"}, od4, e_od);
`ifdef PIPE_REG_ELASTIC_OCC_EN
    check({name, " occ"}, {29'd0, occ4}, e_occ);
`else
    if (e_occ < 0) $display("note: negative occupancy expectation");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst2 = 1'b1; flush2 = 1'b0; stall2 = 1'b0; iv2 = 1'b0; id2 = '0; or2 = 1'b0;
    rst4 = 1'b1; flush4 = 1'b0; stall4 = 1'b0; iv4 = 1'b0; id4 = '0; or4 = 1'b0;

    //  chk rst fl st iv din    ordy ir ov od     occ
    // reset, latency and throughput
    add(0, 1, 0, 0, 0, 32'h0,  1,  0, 0, 32'h0,  0);
    add(1, 0, 0, 0, 1, 32'h11, 1,  1, 0, 32'h0,  0);
    add(1, 0, 0, 0, 1, 32'h22, 1,  1, 0, 32'h0,  1);
    add(1, 0, 0, 0, 1, 32'h33, 1,  1, 1, 32'h11, 2);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 1, 32'h22, 2);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 1, 32'h33, 1);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 0, 32'h0,  0);
    // back-pressure, full, push+pop when full
    add(1, 0, 0, 0, 1, 32'hA,  0,  1, 0, 32'h0,  0);
    add(1, 0, 0, 0, 1, 32'hB,  0,  1, 0, 32'h0,  1);
    add(1, 0, 0, 0, 1, 32'hC,  0,  0, 1, 32'hA,  2);
    add(1, 0, 0, 0, 1, 32'hC,  1,  1, 1, 32'hA,  2);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 1, 32'hB,  2);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 1, 32'hC,  1);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 0, 32'h0,  0);
    // stall for 3 cycles
    add(1, 0, 0, 0, 1, 32'h1,  0,  1, 0, 32'h0,  0);
    add(1, 0, 0, 0, 1, 32'h2,  0,  1, 0, 32'h0,  1);
    add(1, 0, 0, 1, 1, 32'h99, 1,  0, 0, 32'h1,  2);
    add(1, 0, 0, 1, 1, 32'h99, 1,  0, 0, 32'h1,  2);
    add(1, 0, 0, 1, 1, 32'h99, 1,  0, 0, 32'h1,  2);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 1, 32'h1,  2);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 1, 32'h2,  1);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 0, 32'h0,  0);
    // flush together with stall on a full pipe
    add(1, 0, 0, 0, 1, 32'h44, 0,  1, 0, 32'h0,  0);
    add(1, 0, 0, 0, 1, 32'h55, 0,  1, 0, 32'h0,  1);
    add(1, 0, 1, 1, 1, 32'h66, 1,  0, 0, 32'h44, 2);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 0, 32'h0,  0);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 0, 32'h0,  0);
    // reset while streaming
    add(1, 0, 0, 0, 1, 32'h77, 1,  1, 0, 32'h0,  0);
    add(1, 0, 0, 0, 1, 32'h88, 1,  1, 0, 32'h0,  1);
    add(1, 1, 0, 0, 1, 32'h99, 1,  1, 1, 32'h77, 2);
    add(1, 0, 0, 0, 1, 32'hAA, 1,  1, 0, 32'h0,  0);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 0, 32'h0,  1);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 1, 32'hAA, 1);
    add(1, 0, 0, 0, 0, 32'h0,  1,  1, 0, 32'h0,  0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst2 = vq[i].rst; flush2 = vq[i].flush; stall2 = vq[i].stall;
      iv2 = vq[i].iv; id2 = vq[i].din; or2 = vq[i].ordy;
      #1;
      if (vq[i].chk) begin
        check($sformatf("row%0d in_ready", i), {31'd0, ir2}, {31'd0, vq[i].e_ir});
        check($sformatf("row%0d out_valid", i), {31'd0, ov2}, {31'd0, vq[i].e_ov});
        check($sformatf("row%0d out_data", i), od2, vq[i].e_od);
`ifdef PIPE_REG_ELASTIC_OCC_EN
        check($sformatf("row%0d occ", i), {30'd0, occ2}, vq[i].e_occ);
`endif
      end
    end

    // DEPTH=4 bubble collapse: one item walks to the last stage, then fill.
    step4(1, 0, 32'h0, 0);
    step4(0, 1, 32'h5, 0);
    check4("d4 empty", 1, 0, 32'h0, 0);
    step4(0, 0, 32'h0, 0);
    check4("d4 s0", 1, 0, 32'h0, 1);
    step4(0, 0, 32'h0, 0);
    check4("d4 s1", 1, 0, 32'h0, 1);
    step4(0, 0, 32'h0, 0);
    check4("d4 s2", 1, 0, 32'h0, 1);
    step4(0, 1, 32'h6, 0);
    check4("d4 s3 push6", 1, 1, 32'h5, 1);
    step4(0, 1, 32'h7, 0);
    check4("d4 push7", 1, 1, 32'h5, 2);
    step4(0, 1, 32'h8, 0);
    check4("d4 push8", 1, 1, 32'h5, 3);
    step4(0, 1, 32'h9, 0);
    check4("d4 full", 0, 1, 32'h5, 4);
    step4(0, 0, 32'h0, 1);
    check4("d4 pop5", 1, 1, 32'h5, 4);
    step4(0, 0, 32'h0, 1);
    check4("d4 pop6", 1, 1, 32'h6, 3);
    step4(0, 0, 32'h0, 1);
    check4("d4 pop7", 1, 1, 32'h7, 2);
    step4(0, 0, 32'h0, 1);
    check4("d4 pop8", 1, 1, 32'h8, 1);
    step4(0, 0, 32'h0, 1);
    check4("d4 drained", 1, 0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
